som_train_scheduler: RTL and testbench
======================================

# som_train_scheduler

- Sequences SOM training over the input image:
  - Fetches each pixel from the input-feature RAM.
  - Lets the 64-VEP array and the winner-search logic settle.
  - Issues one weight-update strobe per pixel.
  - Repeats for a programmed number of epochs, decaying the neighbourhood radius and learning rate.
- Sits between the top-level controller and the VEP/WSC datapath.
- Owns the RAM_IF read port while busy.

## Interface
Parameters:
- ADDR_W, 18, width of the RAM_IF address.
- NUM_PIX, 16384, pixels per epoch; must be a power of two, ≤ 65536.
- EPOCHS, 8, training epochs; 1..16.
- CMP_LAT, 2, cycles from pixel latch to valid winner_x/y; 1..15.
- RADIUS_INIT, 3, neighbourhood radius in epoch 0.
- LR_SHIFT_INIT, 1, learning-rate right-shift in epoch 0.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin training.
- stall  in  1  RAM_IF is busy elsewhere; holds the fetch.
- ram_if_oe  out  1  RAM_IF read enable.
- ram_if_a  out  ADDR_W  RAM_IF read address.
- pix_latch  out  1  RAM_IF_Q is valid this cycle; VEPs capture the pixel.
- upd_en  out  1  one-cycle weight-update strobe to all VEPs.
- radius  out  3  current neighbourhood radius.
- lr_shift  out  3  current learning-rate shift.
- epoch  out  4  current epoch index.
- busy  out  1  training in progress.
- done  out  1  training finished; held until the next start.

## Operation
- States: IDLE, FETCH, LATCH, SEARCH, UPDATE, NEXT, DONE.
- IDLE / DONE:
  - start=1 clears pix_idx, epoch and the search counter, then moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - stall=1: stay in FETCH with ram_if_oe=0.
  - Otherwise: ram_if_oe=1, ram_if_a=addr(pix_idx), then go to LATCH.
- LATCH: pix_latch=1 (RAM read latency is 1 cycle). Go to SEARCH with cnt=0.
- SEARCH: count to CMP_LAT-1, then go to UPDATE. stall is ignored here.
- UPDATE: upd_en=1 for exactly one cycle; radius and lr_shift are stable. Go to NEXT.
- NEXT:
  - pix_idx ≠ NUM_PIX-1: pix_idx+1, go to FETCH.
  - Last pixel, epoch ≠ EPOCHS-1: pix_idx=0, epoch+1, go to FETCH.
  - Last pixel of last epoch: go to DONE.
- Schedule (combinational from epoch, saturating):
  - radius = epoch ≥ RADIUS_INIT ? 0 : RADIUS_INIT-epoch.
  - lr_shift = min(LR_SHIFT_INIT+epoch, 7).
- Flags: busy=1 in all states except IDLE and DONE. done=1 only in DONE.
- Outputs ram_if_a, radius, lr_shift and epoch are registered or derived from registers; no glitching between strobes.

## Timing
- Reset values:
  - State IDLE.
  - ram_if_oe, pix_latch, upd_en, busy, done all 0.
  - ram_if_a, epoch, radius=RADIUS_INIT, lr_shift=LR_SHIFT_INIT.
- start sampled at edge N: FETCH (ram_if_oe=1) in cycle N+1; pix_latch at N+2; upd_en at N+3+CMP_LAT.
- Per pixel, with no stall: 4+CMP_LAT cycles. Total run: NUM_PIX·EPOCHS·(4+CMP_LAT) cycles.
- Each stall cycle in FETCH adds exactly one cycle.
- Reset asserted mid-run: immediate return to IDLE, all strobes low in the same cycle.

## Configuration
- SOM_SHUFFLE_EN defined:
  - ram_if_a = pix_idx XOR (mask & (NUM_PIX-1)).
  - mask comes from a 16-bit Fibonacci LFSR (taps 16,14,13,11).
  - The LFSR is seeded 16'hACE1 on start and steps once per epoch wrap in NEXT.
  - Every pixel is still visited exactly once per epoch.
- SOM_SHUFFLE_EN undefined:
  - ram_if_a = pix_idx.
  - No LFSR logic is present.

## Structure
- Package som_sched_pkg holds:
  - The state enum.
  - The LFSR seed and tap constants.
  - Output widths (RADIUS_W=3, LRS_W=3, EPOCH_W=4).
- Sub-module som_epoch_lfsr holds the mask generator; it is instantiated only under SOM_SHUFFLE_EN.
- Everything else (FSM, pix_idx, epoch and search counters, schedule decode) lives in one module.

## Test plan
- Basic run, NUM_PIX=4, EPOCHS=2, CMP_LAT=2, start pulse:
  - ram_if_a sequence 0,1,2,3,0,1,2,3.
  - 8 upd_en pulses, 6 cycles apart.
  - done rises 48 cycles after FETCH entry.
- Schedule, EPOCHS=5, RADIUS_INIT=3, LR_SHIFT_INIT=1:
  - Per epoch: radius 3,2,1,0,0; lr_shift 1,2,3,4,5.
- Stall held 3 cycles in FETCH of pixel 2: ram_if_oe low for those cycles; the following upd_en is delayed by exactly 3 cycles.
- start pulsed while busy: no effect on counters. start in DONE: restart, done drops the next cycle, ram_if_a=0.
- Reset (rst=0) asserted during SEARCH: busy, upd_en and pix_latch drop asynchronously; after release, state is IDLE and epoch=0.
- With SOM_SHUFFLE_EN, NUM_PIX=16:
  - Epoch 0 addresses = pix_idx ^ (16'hACE1 & 15) = pix_idx^1.
  - Each epoch covers all 16 addresses exactly once.

Source files
------------

// File: rtl/som_sched_pkg.sv
// som_sched_pkg: shared types and constants for the SOM training scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, epoch-shuffle LFSR seed/taps, schedule output widths.
package som_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_UPDATE = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam int RADIUS_W = 3;
  localparam int LRS_W    = 3;
  localparam int EPOCH_W  = 4;
  localparam int CNT_W    = 4;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10).
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/som_epoch_lfsr.sv
// som_epoch_lfsr: per-epoch address-shuffle mask generator (used only with SOM_SHUFFLE_EN).
// Latency: mask changes the cycle after seed_load or step.
// Backpressure: none; advances only when step is asserted.
// Ports: clk, rst (async active-low), seed_load, step -> mask[OUT_W-1:0] (low bits of LFSR).
module som_epoch_lfsr
  import som_sched_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic             step,
  output logic [OUT_W-1:0] mask
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // NUM_PIX is a power of two, so masking with NUM_PIX-1 is just the low bits.
  assign mask = lfsr[OUT_W-1:0];

endmodule

// File: rtl/som_train_scheduler.sv
// som_train_scheduler: sequences SOM training (fetch pixel, latch, winner search, update) over epochs.
// Latency: start -> FETCH next cycle; 4+CMP_LAT cycles per pixel without stall.
// Backpressure: stall holds the FSM in FETCH (ram_if_oe low); stall is ignored elsewhere.
// Ports: clk, rst (async active-low), start, stall -> ram_if_oe, ram_if_a, pix_latch, upd_en,
//        radius, lr_shift, epoch, busy, done.
// Optional: define SOM_SHUFFLE_EN to XOR the read address with a per-epoch LFSR mask.
module som_train_scheduler
  import som_sched_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int NUM_PIX       = 16384,
  parameter int EPOCHS        = 8,
  parameter int CMP_LAT       = 2,
  parameter int RADIUS_INIT   = 3,
  parameter int LR_SHIFT_INIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  output logic                ram_if_oe,
  output logic [ADDR_W-1:0]   ram_if_a,
  output logic                pix_latch,
  output logic                upd_en,
  output logic [RADIUS_W-1:0] radius,
  output logic [LRS_W-1:0]    lr_shift,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                busy,
  output logic                done
);

  localparam int                 PIX_W      = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(NUM_PIX - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CMP_LAT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [PIX_W-1:0]   pix_idx;
  logic [CNT_W-1:0]   cnt;
  logic               start_ok;
  logic               last_pix;
  logic               last_epoch;
  logic               search_end;

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_pix   = (pix_idx == PIX_LAST);
  assign last_epoch = (epoch == EPOCH_LAST);
  assign search_end = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         if (!stall) state_d = ST_LATCH;
      ST_LATCH:         state_d = ST_SEARCH;
      ST_SEARCH:        if (search_end) state_d = ST_UPDATE;
      ST_UPDATE:        state_d = ST_NEXT;
      ST_NEXT:          state_d = (last_pix && last_epoch) ? ST_DONE : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; ram_if_oe also honours stall.
  always_comb begin
    ram_if_oe = (state_q == ST_FETCH) && !stall;
    pix_latch = (state_q == ST_LATCH);
    upd_en    = (state_q == ST_UPDATE);
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
  end

  // Pixel, epoch and search counters. On the final pixel of the final epoch the
  // counters hold, so DONE keeps showing the last address/epoch until restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_idx <= '0;
      epoch   <= '0;
      cnt     <= '0;
    end else if (start_ok) begin
      pix_idx <= '0;
      epoch   <= '0;
      cnt     <= '0;
    end else begin
      case (state_q)
        ST_LATCH:  cnt <= '0;
        ST_SEARCH: cnt <= cnt + 1'b1;
        ST_NEXT: begin
          if (!last_pix) begin
            pix_idx <= pix_idx + 1'b1;
          end else if (!last_epoch) begin
            pix_idx <= '0;
            epoch   <= epoch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating decay schedule, derived purely from the epoch register.
  always_comb begin
    if (int'(epoch) >= RADIUS_INIT) begin
      radius = '0;
    end else begin
      radius = RADIUS_W'(RADIUS_INIT - int'(epoch));
    end
    if (LR_SHIFT_INIT + int'(epoch) >= 7) begin
      lr_shift = 3'd7;
    end else begin
      lr_shift = LRS_W'(LR_SHIFT_INIT + int'(epoch));
    end
  end

`ifdef SOM_SHUFFLE_EN
  logic [PIX_W-1:0] mask;
  logic             lfsr_step;

  // Step once per epoch wrap; XOR with a fixed mask is a bijection, so every
  // pixel is still visited exactly once per epoch.
  assign lfsr_step = (state_q == ST_NEXT) && last_pix && !last_epoch;

  som_epoch_lfsr #(
    .OUT_W(PIX_W)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (start_ok),
    .step      (lfsr_step),
    .mask      (mask)
  );

  assign ram_if_a = ADDR_W'(pix_idx ^ mask);
`else
  assign ram_if_a = ADDR_W'(pix_idx);
`endif

endmodule

// File: tb/tb_som_train_scheduler.sv
// tb_som_train_scheduler: directed bench for som_train_scheduler with a slot-arithmetic
// reference model compared every cycle, plus literal checks of address order, strobe spacing,
// schedule values, restart and asynchronous reset.
module tb_som_train_scheduler;

  localparam int ADDR_W = 18;
  localparam int NP     = 4;
  localparam int EP     = 5;
  localparam int CL     = 2;
  localparam int RI     = 3;
  localparam int LI     = 1;
  localparam int SLOT   = 4 + CL;
  localparam int TOTAL  = NP * EP * SLOT;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic              ram_if_oe;
  logic [ADDR_W-1:0] ram_if_a;
  logic              pix_latch;
  logic              upd_en;
  logic [2:0]        radius;
  logic [2:0]        lr_shift;
  logic [3:0]        epoch;
  logic              busy;
  logic              done;

  som_train_scheduler #(
    .ADDR_W(ADDR_W), .NUM_PIX(NP), .EPOCHS(EP), .CMP_LAT(CL),
    .RADIUS_INIT(RI), .LR_SHIFT_INIT(LI)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .ram_if_oe(ram_if_oe), .ram_if_a(ram_if_a), .pix_latch(pix_latch), .upd_en(upd_en),
    .radius(radius), .lr_shift(lr_shift), .epoch(epoch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // mcyc counts productive cycles since FETCH entry; a stalled fetch slot does not advance it.
  int m_run  = 0;
  int m_cyc  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0;
      m_cyc = 0;
    end else if (m_run == 0 || m_cyc >= TOTAL) begin
      if (start) begin
        m_run = 1;
        m_cyc = 0;
      end
    end else if (!((m_cyc % SLOT) == 0 && stall)) begin
      m_cyc = m_cyc + 1;
    end
  end

  function automatic int model_addr(input int pix, input int ep);
    int a;
    a = pix;
`ifdef SOM_SHUFFLE_EN
    begin
      logic [15:0] s;
      s = 16'hACE1;
      for (int k = 0; k < ep; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      a = pix ^ (int'(s) & (NP - 1));
    end
`else
    a = a + 0 * ep;
`endif
    return a;
  endfunction

  function automatic int exp_radius(input int ep);
    return (ep >= RI) ? 0 : RI - ep;
  endfunction

  function automatic int exp_lrs(input int ep);
    return (LI + ep > 7) ? 7 : LI + ep;
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [32:0] e_vec;
    logic [32:0] a_vec;
    int g, o, ep, pix;
    logic b, d, oe, pl, up;
    b = 0; d = 0; oe = 0; pl = 0; up = 0; ep = 0; pix = 0;
    if (m_run != 0) begin
      if (m_cyc >= TOTAL) begin
        d   = 1;
        g   = NP * EP - 1;
      end else begin
        g   = m_cyc / SLOT;
        o   = m_cyc % SLOT;
        b   = 1;
        oe  = (o == 0) && !stall;
        pl  = (o == 1);
        up  = (o == 2 + CL);
      end
      ep  = g / NP;
      pix = g % NP;
    end
    e_vec = {b, d, oe, pl, up, ADDR_W'(model_addr(pix, ep)), 4'(ep),
             3'(exp_radius(ep)), 3'(exp_lrs(ep))};
    a_vec = {busy, done, ram_if_oe, pix_latch, upd_en, ram_if_a, epoch, radius, lr_shift};
    check("cycle_outputs", longint'(a_vec), longint'(e_vec));
  end

  // ---------------- event recorder for literal checks ----------------
  bit rec_en    = 0;
  int fetch_t   = -1;
  int done_t    = -1;
  int addr_q[$];
  int upd_t[$];
  int upd_rad[$];
  int upd_lrs[$];
  int upd_ep[$];

  always @(negedge clk) begin
    if (rec_en) begin
      if (ram_if_oe) begin
        if (fetch_t < 0) fetch_t = cyc;
        addr_q.push_back(int'(ram_if_a));
      end
      if (upd_en) begin
        upd_t.push_back(cyc);
        upd_rad.push_back(int'(radius));
        upd_lrs.push_back(int'(lr_shift));
        upd_ep.push_back(int'(epoch));
      end
      if (done && done_t < 0) done_t = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int rad_lit[5] = '{3, 2, 1, 0, 0};
  int lrs_lit[5] = '{1, 2, 3, 4, 5};

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    tick(3);
    // Reset state, hand-computed.
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_oe",     ram_if_oe, 0);
    check("rst_upd",    upd_en, 0);
    check("rst_epoch",  epoch, 0);
    check("rst_radius", radius, 3);
    check("rst_lrs",    lr_shift, 1);
    rst = 1'b1;
    tick(2);

    // Run: start pulse, 3-cycle stall in pixel 2's fetch, a start while busy.
    rec_en = 1;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    tick(12);
    check("stall_in_fetch", ram_if_oe, 1);
    stall = 1'b1;
    tick(3);
    stall = 1'b0;
    tick(20);
    check("busy_mid_run", busy, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) tick(1);
    check("done_reached", done, 1);
    tick(2);
    rec_en = 0;

    check("upd_count",  upd_t.size(), NP * EP);
    check("addr_count", addr_q.size(), NP * EP);
    if (fetch_t >= 0 && upd_t.size() > 0) check("first_upd_lat", upd_t[0] - fetch_t, 4);
    check("done_after_fetch", done_t - fetch_t, TOTAL + 3);
    for (int i = 1; i < upd_t.size(); i++)
      check("upd_spacing", upd_t[i] - upd_t[i-1], (i == 2) ? 9 : 6);
`ifndef SOM_SHUFFLE_EN
    for (int i = 0; i < addr_q.size(); i++) check("addr_seq", addr_q[i], i % 4);
`else
    for (int e = 0; e < EP; e++) begin
      int seen;
      seen = 0;
      for (int i = 0; i < NP; i++)
        if (e * NP + i < addr_q.size()) seen = seen | (1 << addr_q[e * NP + i]);
      check("epoch_cover", seen, 15);
    end
`endif
    for (int e = 0; e < EP; e++) begin
      if (e * NP < upd_t.size()) begin
        check("sched_radius", upd_rad[e * NP], rad_lit[e]);
        check("sched_lrs",    upd_lrs[e * NP], lrs_lit[e]);
        check("sched_epoch",  upd_ep[e * NP], e);
      end
    end

    // Restart from DONE.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    #1;
    check("restart_done_low", done, 0);
    check("restart_busy",     busy, 1);
    check("restart_epoch",    epoch, 0);
`ifndef SOM_SHUFFLE_EN
    check("restart_addr",     ram_if_a, 0);
`endif

    // Asynchronous reset during SEARCH.
    tick(2);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async_busy",  busy, 0);
    check("async_upd",   upd_en, 0);
    check("async_latch", pix_latch, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("post_rst_busy",  busy, 0);
    check("post_rst_done",  done, 0);
    check("post_rst_epoch", epoch, 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
